// File: rtl/dnnacc_wb_ctrl_if.sv
// Wishbone classic slave bus bundle between the Caravel host port and
// dnnacc_wb_ctrl. The master modport is the host side, the slave modport is
// the CSR block.
interface dnnacc_wb_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/dnnacc_wb_ctrl.sv
// Wishbone CSR bank and byte-stream FIFOs for the DNN accelerator.
// TX FIFO feeds the accelerator over valid/ready; RX FIFO captures bytes
// strobed back by acc_new_i. Define DNNACC_WB_LOOPBACK_EN to add the CTRL[7]
// loopback path (TX head pushed straight into RX, accelerator side muted).
module dnnacc_wb_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned SEL_W      = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    dnnacc_wb_ctrl_if.slave   wb,
    output logic [DATA_W-1:0] acc_data_o,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    input  logic [DATA_W-1:0] acc_data_i,
    input  logic              acc_new_i,
    output logic              en_o,
    output logic [SEL_W-1:0]  sel_pe_o,
    output logic [7:0]        aux_o,
    output logic              irq_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Control registers
    logic             en_q;
    logic [SEL_W-1:0] sel_q;
    logic [7:0]       aux_q;
    logic [2:0]       irq_en_q;
    logic [2:0]       irq_stat_q;

    // FIFO state
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CNT_W-1:0]  tx_cnt_q, rx_cnt_q;
    logic              tx_ovf_q, rx_ovf_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    assign tx_full  = (tx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CNT_W'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    // Bus decode: one request per access because ack masks the strobe
    logic       req, wr, rd;
    logic [2:0] idx;
    assign req = wb.wbs_stb_i & wb.wbs_cyc_i & ~wb.wbs_ack_o;
    assign wr  = req & wb.wbs_we_i;
    assign rd  = req & ~wb.wbs_we_i;
    assign idx = wb.wbs_adr_i[4:2];

    logic ctrl_wr_lo, ctrl_wr_hi, flush, tx_push_req, rx_pop;
    logic irq_en_wr, irq_stat_wr;
    assign ctrl_wr_lo  = wr & (idx == 3'd0) & wb.wbs_sel_i[0];
    assign ctrl_wr_hi  = wr & (idx == 3'd0) & wb.wbs_sel_i[1];
    assign flush       = ctrl_wr_lo & wb.wbs_dat_i[1];
    assign tx_push_req = wr & (idx == 3'd2) & (wb.wbs_sel_i[0] | wb.wbs_sel_i[1]);
    assign rx_pop      = rd & (idx == 3'd3) & ~rx_empty;
    assign irq_en_wr   = wr & (idx == 3'd4) & wb.wbs_sel_i[0];
    assign irq_stat_wr = wr & (idx == 3'd5) & wb.wbs_sel_i[0];

    logic              tx_pop, rx_push_req, lb_bit;
    logic [DATA_W-1:0] rx_push_data;

`ifdef DNNACC_WB_LOOPBACK_EN
    logic lb_q;

    // Loopback enable lives in CTRL[7]
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            lb_q <= 1'b0;
        else if (ctrl_wr_lo)
            lb_q <= wb.wbs_dat_i[7];
    end

    assign lb_bit       = lb_q;
    assign acc_valid_o  = ~lb_q & en_q & ~tx_empty;
    assign tx_pop       = lb_q ? (~tx_empty & ~rx_full) : (acc_valid_o & acc_ready_i);
    assign rx_push_req  = lb_q ? tx_pop : (acc_new_i & en_q);
    assign rx_push_data = lb_q ? tx_mem[tx_rd_q] : acc_data_i;
`else
    assign lb_bit       = 1'b0;
    assign acc_valid_o  = en_q & ~tx_empty;
    assign tx_pop       = acc_valid_o & acc_ready_i;
    assign rx_push_req  = acc_new_i & en_q;
    assign rx_push_data = acc_data_i;
`endif

    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    logic tx_push_ok, tx_drop, rx_push_ok, rx_drop;
    assign tx_push_ok = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop    = tx_push_req & ~tx_push_ok;
    assign rx_push_ok = rx_push_req & (~rx_full | rx_pop);
    assign rx_drop    = rx_push_req & ~rx_push_ok;

    logic [2:0] irq_evt;
    assign irq_evt[0] = ~flush & rx_push_ok & rx_empty;
    assign irq_evt[1] = ~flush & tx_pop & ~tx_push_ok & (tx_cnt_q == CNT_W'(1));
    assign irq_evt[2] = tx_drop | rx_drop;

    assign acc_data_o = tx_mem[tx_rd_q];
    assign en_o       = en_q;
    assign sel_pe_o   = sel_q;
    assign aux_o      = aux_q;
    assign irq_o      = |(irq_stat_q & irq_en_q);

    // Read mux, sampled into wbs_dat_o on the request edge
    logic [31:0] ctrl_rd, rd_data;
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[0] = en_q;
        ctrl_rd[2 +: SEL_W] = sel_q;
        ctrl_rd[7] = lb_bit;
        ctrl_rd[15:8] = aux_q;
        rd_data = '0;
        unique case (idx)
            3'd0: rd_data = ctrl_rd;
            3'd1: rd_data = {10'd0, rx_ovf_q, tx_ovf_q, rx_empty, rx_full,
                             tx_empty, tx_full, 8'(rx_cnt_q), 8'(tx_cnt_q)};
            3'd3: rd_data = rx_empty ? '0 : 32'(rx_mem[rx_rd_q]);
            3'd4: rd_data = {29'd0, irq_en_q};
            3'd5: rd_data = {29'd0, irq_stat_q};
            default: rd_data = '0;
        endcase
    end

    // Wishbone response and CSR updates
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
            en_q         <= 1'b0;
            sel_q        <= '0;
            aux_q        <= '0;
            irq_en_q     <= '0;
            irq_stat_q   <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            if (req)
                wb.wbs_dat_o <= wb.wbs_we_i ? '0 : rd_data;
            if (ctrl_wr_lo) begin
                en_q  <= wb.wbs_dat_i[0];
                sel_q <= wb.wbs_dat_i[2 +: SEL_W];
            end
            if (ctrl_wr_hi)
                aux_q <= wb.wbs_dat_i[15:8];
            if (irq_en_wr)
                irq_en_q <= wb.wbs_dat_i[2:0];
            // A new event in the clearing cycle survives the W1C
            irq_stat_q <= (irq_stat_q & ~(irq_stat_wr ? wb.wbs_dat_i[2:0] : 3'b000)) | irq_evt;
        end
    end

    // FIFO pointers, counts and sticky overflow; flush overrides everything
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i || flush) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            tx_ovf_q <= 1'b0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (tx_push_ok) tx_wr_q <= tx_wr_q + PTR_W'(1);
            if (tx_pop)     tx_rd_q <= tx_rd_q + PTR_W'(1);
            unique case ({tx_push_ok, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                2'b01:   tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                default: tx_cnt_q <= tx_cnt_q;
            endcase
            if (tx_drop) tx_ovf_q <= 1'b1;

            if (rx_push_ok) rx_wr_q <= rx_wr_q + PTR_W'(1);
            if (rx_pop)     rx_rd_q <= rx_rd_q + PTR_W'(1);
            unique case ({rx_push_ok, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                2'b01:   rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                default: rx_cnt_q <= rx_cnt_q;
            endcase
            if (rx_drop) rx_ovf_q <= 1'b1;
        end
    end

    // FIFO storage, written at the tail on an accepted push
    always_ff @(posedge wb_clk_i) begin
        if (tx_push_ok) tx_mem[tx_wr_q] <= wb.wbs_dat_i[DATA_W-1:0];
        if (rx_push_ok) rx_mem[rx_wr_q] <= rx_push_data;
    end

    logic unused_bits;
    assign unused_bits = ^{wb.wbs_adr_i[31:5], wb.wbs_adr_i[1:0],
                           wb.wbs_sel_i[3:2], wb.wbs_dat_i};
endmodule

// File: tb/tb_dnnacc_wb_ctrl.sv
// Self-checking bench for dnnacc_wb_ctrl (default build, loopback disabled).
// Expected register reads and expected TX bytes are queued when stimulus is
// driven and compared when the DUT answers.
module tb_dnnacc_wb_ctrl;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SEL_W      = 2;

    localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_TX = 32'h08,
                            A_RX = 32'h0C, A_IEN = 32'h10, A_IST = 32'h14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] acc_data_o;
    logic              acc_valid_o;
    logic              acc_ready_i = 1'b0;
    logic [DATA_W-1:0] acc_data_i = '0;
    logic              acc_new_i = 1'b0;
    logic              en_o;
    logic [SEL_W-1:0]  sel_pe_o;
    logic [7:0]        aux_o;
    logic              irq_o;

    dnnacc_wb_ctrl_if wb_if ();

    dnnacc_wb_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wb          (wb_if.slave),
        .acc_data_o  (acc_data_o),
        .acc_valid_o (acc_valid_o),
        .acc_ready_i (acc_ready_i),
        .acc_data_i  (acc_data_i),
        .acc_new_i   (acc_new_i),
        .en_o        (en_o),
        .sel_pe_o    (sel_pe_o),
        .aux_o       (aux_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd_q[$];
    logic [31:0] tx_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input int txc, input int rxc,
                                                input bit txo, input bit rxo);
        logic [31:0] w;
        w = '0;
        w[7:0]  = 8'(txc);
        w[15:8] = 8'(rxc);
        w[16]   = (txc == FIFO_DEPTH);
        w[17]   = (txc == 0);
        w[18]   = (rxc == FIFO_DEPTH);
        w[19]   = (rxc == 0);
        w[20]   = txo;
        w[21]   = rxo;
        return w;
    endfunction

    task automatic wb_cycle(input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, output logic [31:0] rdat);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = we;
        wb_if.wbs_adr_i = adr;
        wb_if.wbs_dat_i = dat;
        wb_if.wbs_sel_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb_if.wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        rdat = wb_if.wbs_dat_o;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        if (!got) chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] unused_rd;
        wb_cycle(1'b1, adr, dat, unused_rd);
    endtask

    task automatic wb_read_exp(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r, e;
        rd_q.push_back(exp);
        wb_cycle(1'b0, adr, '0, r);
        e = rd_q.pop_front();
        chk(tag, r, e);
        @(posedge clk); #1;
        chk({tag, "_ack_single"}, 32'(wb_if.wbs_ack_o), 32'd0);
    endtask

    task automatic tx_push(input logic [7:0] b, input bit expect_out);
        if (expect_out) tx_q.push_back(32'(b));
        wb_write(A_TX, 32'(b));
    endtask

    task automatic acc_strobe(input logic [7:0] b);
        @(posedge clk); #1;
        acc_new_i  = 1'b1;
        acc_data_i = b;
        @(posedge clk); #1;
        acc_new_i  = 1'b0;
    endtask

    task automatic drain_tx(input string tag);
        bit done;
        done = 1'b0;
        acc_ready_i = 1'b1;
        for (int i = 0; i < 4 * FIFO_DEPTH; i++) begin
            @(posedge clk); #1;
            if (!acc_valid_o) begin
                done = 1'b1;
                break;
            end
        end
        acc_ready_i = 1'b0;
        if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
        chk({tag, "_q_left"}, 32'(tx_q.size()), 32'd0);
    endtask

    // Every accelerator-side transfer must match the next queued TX byte
    always @(negedge clk) begin
        if (!rst && acc_valid_o && acc_ready_i) begin
            if (tx_q.size() == 0)
                chk("tx_extra", 32'(tx_q.size()), 32'd1);
            else
                chk("tx_byte", 32'(acc_data_o), tx_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dummy;
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_sel_i = 4'h0;
        wb_if.wbs_adr_i = '0;
        wb_if.wbs_dat_i = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   32'(wb_if.wbs_ack_o), 32'd0);
        chk("rst_dat",   wb_if.wbs_dat_o, 32'd0);
        chk("rst_en",    32'(en_o), 32'd0);
        chk("rst_sel",   32'(sel_pe_o), 32'd0);
        chk("rst_aux",   32'(aux_o), 32'd0);
        chk("rst_valid", 32'(acc_valid_o), 32'd0);
        chk("rst_irq",   32'(irq_o), 32'd0);
        rst = 1'b0;
        wb_read_exp("rst_status", A_STAT, 32'h000A_0000);
        wb_read_exp("rst_irq_en", A_IEN, 32'd0);
        wb_read_exp("rst_irq_st", A_IST, 32'd0);

        // CTRL write, outputs visible once ack is seen
        wb_write(A_CTRL, 32'h0000_A50D);
        chk("ctrl_en",  32'(en_o), 32'd1);
        chk("ctrl_sel", 32'(sel_pe_o), 32'd3);
        chk("ctrl_aux", 32'(aux_o), 32'hA5);
        wb_read_exp("ctrl_rb", A_CTRL, 32'h0000_A50D);

        // Three bytes streamed once ready rises
        tx_push(8'h11, 1'b1);
        tx_push(8'h22, 1'b1);
        tx_push(8'h33, 1'b1);
        chk("tx_valid", 32'(acc_valid_o), 32'd1);
        chk("tx_head",  32'(acc_data_o), 32'h11);
        wb_read_exp("tx3_status", A_STAT, status_word(3, 0, 1'b0, 1'b0));
        drain_tx("tx3_drain");
        chk("tx3_valid_low", 32'(acc_valid_o), 32'd0);
        wb_read_exp("tx3_irq", A_IST, 32'h2);
        wb_write(A_IST, 32'h2);
        wb_read_exp("tx3_irq_clr", A_IST, 32'h0);

        // Overfill TX; the last write is dropped
        for (int unsigned i = 0; i <= FIFO_DEPTH; i++)
            tx_push(8'(8'hA0 + i), i < FIFO_DEPTH);
        wb_read_exp("ovf_status", A_STAT, status_word(FIFO_DEPTH, 0, 1'b1, 1'b0));
        wb_read_exp("ovf_irq", A_IST, 32'h4);
        chk("ovf_irq_o_masked", 32'(irq_o), 32'd0);
        wb_write(A_IEN, 32'h4);
        chk("ovf_irq_o", 32'(irq_o), 32'd1);
        wb_write(A_IST, 32'h4);
        chk("ovf_irq_o_clr", 32'(irq_o), 32'd0);

        // Push while full in the same cycle as an accelerator pop
        tx_q.push_back(32'h77);
        @(posedge clk); #1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = 1'b1;
        wb_if.wbs_adr_i = A_TX;
        wb_if.wbs_dat_i = 32'h77;
        wb_if.wbs_sel_i = 4'hF;
        acc_ready_i = 1'b1;
        @(posedge clk); #1;
        acc_ready_i = 1'b0;
        chk("sim_ack", 32'(wb_if.wbs_ack_o), 32'd1);
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_we_i  = 1'b0;
        wb_read_exp("sim_status", A_STAT, status_word(FIFO_DEPTH, 0, 1'b1, 1'b0));
        wb_read_exp("sim_no_ovf", A_IST, 32'h0);
        drain_tx("wrap_drain");

        // Flush clears sticky overflow and reads back as 0
        wb_write(A_CTRL, 32'h0000_A50F);
        wb_read_exp("flush_status", A_STAT, status_word(0, 0, 1'b0, 1'b0));
        wb_read_exp("flush_ctrl", A_CTRL, 32'h0000_A50D);
        wb_write(A_IST, 32'h7);

        // RX capture and pops
        acc_strobe(8'h5A);
        acc_strobe(8'hC3);
        wb_read_exp("rx_status", A_STAT, status_word(0, 2, 1'b0, 1'b0));
        wb_read_exp("rx_irq", A_IST, 32'h1);
        wb_read_exp("rx_pop0", A_RX, 32'h5A);
        wb_read_exp("rx_pop1", A_RX, 32'hC3);
        wb_read_exp("rx_pop_empty", A_RX, 32'h0);
        wb_read_exp("rx_status_end", A_STAT, status_word(0, 0, 1'b0, 1'b0));

        // Disabled: acc_new_i ignored and no valid toward the accelerator
        wb_write(A_CTRL, 32'h0);
        chk("dis_en", 32'(en_o), 32'd0);
        acc_strobe(8'h99);
        tx_push(8'h44, 1'b0);
        acc_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("dis_valid", 32'(acc_valid_o), 32'd0);
        acc_ready_i = 1'b0;
        wb_read_exp("dis_status", A_STAT, status_word(1, 0, 1'b0, 1'b0));

        // Reset during a pending access drops the ack
        wb_write(A_CTRL, 32'h0000_0001);
        @(posedge clk); #1;
        wb_if.wbs_stb_i = 1'b1;
        wb_if.wbs_cyc_i = 1'b1;
        wb_if.wbs_we_i  = 1'b0;
        wb_if.wbs_adr_i = A_STAT;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(wb_if.wbs_ack_o), 32'd0);
        chk("rst_mid_en",  32'(en_o), 32'd0);
        wb_if.wbs_stb_i = 1'b0;
        wb_if.wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read_exp("rst_mid_status", A_STAT, 32'h000A_0000);
        dummy = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
